ulpb_tx_queue: RTL and testbench
================================

# ulpb_tx_queue

Transmit message queue sitting directly upstream of `ulpb_node` on the layer side. Buffers address/data messages written by the local layer controller and presents them one at a time to the node's `ADDR_IN`/`DATA_IN`/`REQ_TX`/`ACK_TX` four-phase handshake. Lets the layer post messages back-to-back without waiting for bus arbitration.

## Interface
- `ADDR_WIDTH`, 8, message address width; matches node.
- `DATA_WIDTH`, 32, message payload width; matches node.
- `DEPTH`, 4, queue entries; power of two, ≥2.
- `TIMEOUT`, 255, max cycles in REQ before abandoning a message (only with `ULPB_TXQ_TIMEOUT_EN`).

Ports:
- `CLK` in 1: bus clock (same `SCLK` as the node).
- `RESET` in 1: reset; one clock, synchronous, active-high.
- `WR_ADDR` in ADDR_WIDTH: address of message to enqueue.
- `WR_DATA` in DATA_WIDTH: payload of message to enqueue.
- `WR_EN` in 1: enqueue strobe, one message per cycle.
- `FULL` out 1: queue holds DEPTH entries.
- `EMPTY` out 1: queue holds 0 entries.
- `COUNT` out log2(DEPTH)+1: occupancy.
- `DROP` out 1: one-cycle pulse, write ignored because FULL.
- `ADDR_OUT` out ADDR_WIDTH: to node `ADDR_IN`.
- `DATA_OUT` out DATA_WIDTH: to node `DATA_IN`.
- `REQ_TX` out 1: to node `REQ_TX`.
- `ACK_TX` in 1: from node `ACK_TX`.
- `SENT` out 1: one-cycle pulse, head message acknowledged.
- `TIMEOUT_ERR` out 1: one-cycle pulse, head message abandoned (macro only; tied 0 otherwise).

## Operation
- States: IDLE, REQ, RELEASE.
- IDLE: if !EMPTY and !ACK_TX → load head into `ADDR_OUT`/`DATA_OUT`, assert `REQ_TX`, go REQ.
- REQ: hold `REQ_TX`=1 and outputs stable. On ACK_TX=1 → drop `REQ_TX`, pop head, pulse `SENT`, go RELEASE.
- RELEASE: `REQ_TX`=0; wait ACK_TX=0 → IDLE. No new request while ACK_TX high.
- Write: `WR_EN` & !FULL stores at tail; `WR_EN` & FULL ignored, `DROP` pulses.
- Same-cycle write and pop: both take effect; COUNT unchanged. FULL is evaluated on the pre-edge count, so a write in the pop cycle while FULL is dropped.
- Pointers wrap modulo DEPTH; COUNT is a separate counter, 0..DEPTH.
- Messages leave strictly in FIFO order; the queue never reorders or duplicates.
- Reset (any state, including mid-handshake): queue emptied, state IDLE. The node sees REQ_TX fall and handles it as a withdrawn request.
- Reset values: REQ_TX=0, ADDR_OUT=0, DATA_OUT=0, COUNT=0, EMPTY=1, FULL=0, DROP=0, SENT=0, TIMEOUT_ERR=0.

## Timing
- All outputs registered.
- Write at edge t → COUNT/EMPTY update at t; earliest REQ_TX=1 at edge t+1 when idle.
- ACK_TX sampled high at edge a → REQ_TX=0, SENT=1, COUNT−1 at edge a. SENT is 0 at a+1.
- Minimum message spacing: REQ rise, ACK, ACK fall, then REQ rise one cycle later in IDLE.
- ADDR_OUT/DATA_OUT change only on the IDLE→REQ transition.

## Configuration
- `ULPB_TXQ_TIMEOUT_EN` defined:
  - A cycle counter runs in REQ.
  - If ACK_TX is still 0 after TIMEOUT cycles in REQ: REQ_TX=0, head popped (discarded), `TIMEOUT_ERR` pulses, go RELEASE.
  - Counter clears on entry to REQ.
- Undefined: no counter logic; REQ held indefinitely; `TIMEOUT_ERR` tied 0.

## Structure
- Shared package `ulpb_pkg`: ADDR_WIDTH/DATA_WIDTH defaults and the tx-queue state enum (IDLE/REQ/RELEASE).
- Submodule `ulpb_sync_fifo`: storage, pointers, COUNT/FULL/EMPTY, push/pop.
- Top level holds the handshake FSM, the output registers and the timeout counter.

## Test plan
- Reset, then write {ab, abcdef12}; emulated node raises ACK_TX 3 cycles after REQ_TX → REQ_TX rises 1 cycle after the write; SENT pulses once; COUNT returns to 0; ADDR_OUT=ab and DATA_OUT=abcdef12 stable throughout REQ.
- Four back-to-back writes (DEPTH=4), then a fifth → FULL=1, DROP pulses on the fifth; exactly four SENT pulses delivered in write order.
- Write and ACK-pop in the same cycle with COUNT=2 → COUNT stays 2; no entry lost.
- Node holds ACK_TX high 5 cycles after REQ_TX falls → no new REQ_TX until ACK_TX=0, then REQ_TX rises the next cycle.
- RESET asserted in REQ with COUNT=3 → next cycle REQ_TX=0, COUNT=0, EMPTY=1; all outputs at reset values.
- With `ULPB_TXQ_TIMEOUT_EN`, TIMEOUT=8, ACK_TX never asserted → REQ_TX falls after 8 cycles; TIMEOUT_ERR pulses; COUNT decrements; next message is then requested.

Source files
------------

// File: rtl/ulpb_pkg.sv
// Shared ULPB definitions: default message field widths and the tx-queue
// handshake state encoding.
package ulpb_pkg;

  localparam int ULPB_ADDR_WIDTH = 8;
  localparam int ULPB_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    TXQ_IDLE    = 2'd0,
    TXQ_REQ     = 2'd1,
    TXQ_RELEASE = 2'd2
  } txq_state_t;

endpackage

// File: rtl/ulpb_sync_fifo.sv
// Single-clock message FIFO with a separate occupancy counter and registered
// full/empty flags; a write while full is ignored and reported on drop.
module ulpb_sync_fifo
  import ulpb_pkg::*;
#(
  parameter int WIDTH = 40,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     drop
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_nxt;
  logic             push;

  // full is the pre-edge flag, so a write coinciding with a pop while full is lost
  assign push    = wr_en & ~full;
  assign rd_data = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    case ({push, rd_en})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      drop   <= 1'b0;
    end else begin
      drop  <= wr_en & full;
      count <= count_nxt;
      full  <= (count_nxt == FULL_CNT);
      empty <= (count_nxt == '0);
      if (push)  wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/ulpb_tx_queue.sv
// Transmit queue feeding ulpb_node over the REQ_TX/ACK_TX four-phase handshake.
// Optional REQ abandonment timer is enabled with `define ULPB_TXQ_TIMEOUT_EN.
module ulpb_tx_queue
  import ulpb_pkg::*;
#(
  parameter int ADDR_WIDTH = ULPB_ADDR_WIDTH,
  parameter int DATA_WIDTH = ULPB_DATA_WIDTH,
  parameter int DEPTH      = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [ADDR_WIDTH-1:0]  WR_ADDR,
  input  logic [DATA_WIDTH-1:0]  WR_DATA,
  input  logic                   WR_EN,
  output logic                   FULL,
  output logic                   EMPTY,
  output logic [$clog2(DEPTH):0] COUNT,
  output logic                   DROP,
  output logic [ADDR_WIDTH-1:0]  ADDR_OUT,
  output logic [DATA_WIDTH-1:0]  DATA_OUT,
  output logic                   REQ_TX,
  input  logic                   ACK_TX,
  output logic                   SENT,
  output logic                   TIMEOUT_ERR
);

  localparam int MSG_W = ADDR_WIDTH + DATA_WIDTH;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_param
    $error("ulpb_tx_queue: DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
  end

  txq_state_t       state;
  logic [MSG_W-1:0] head;
  logic             pop;
  logic             timeout_hit;

  ulpb_sync_fifo #(
    .WIDTH (MSG_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (CLK),
    .rst     (RESET),
    .wr_en   (WR_EN),
    .wr_data ({WR_ADDR, WR_DATA}),
    .rd_en   (pop),
    .rd_data (head),
    .full    (FULL),
    .empty   (EMPTY),
    .count   (COUNT),
    .drop    (DROP)
  );

  // head leaves the queue on acknowledge or on abandonment, never otherwise
  assign pop = (state == TXQ_REQ) && (ACK_TX || timeout_hit);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= TXQ_IDLE;
      REQ_TX   <= 1'b0;
      SENT     <= 1'b0;
      ADDR_OUT <= '0;
      DATA_OUT <= '0;
    end else begin
      SENT <= 1'b0;
      case (state)
        TXQ_IDLE: begin
          if (!EMPTY && !ACK_TX) begin
            ADDR_OUT <= head[MSG_W-1:DATA_WIDTH];
            DATA_OUT <= head[DATA_WIDTH-1:0];
            REQ_TX   <= 1'b1;
            state    <= TXQ_REQ;
          end
        end
        TXQ_REQ: begin
          if (pop) begin
            REQ_TX <= 1'b0;
            SENT   <= ACK_TX;
            state  <= TXQ_RELEASE;
          end
        end
        TXQ_RELEASE: begin
          if (!ACK_TX) state <= TXQ_IDLE;
        end
        default: state <= TXQ_IDLE;
      endcase
    end
  end

`ifdef ULPB_TXQ_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  logic [TMR_W-1:0] tmr;

  // counter sits at zero outside REQ, so it is clear on every entry to REQ
  assign timeout_hit = (state == TXQ_REQ) && (tmr == TMR_W'(TIMEOUT - 1));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      tmr         <= '0;
      TIMEOUT_ERR <= 1'b0;
    end else begin
      TIMEOUT_ERR <= timeout_hit && !ACK_TX;
      if (state != TXQ_REQ) tmr <= '0;
      else                  tmr <= tmr + TMR_W'(1);
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign TIMEOUT_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_ulpb_tx_queue.sv
// Randomized scoreboard bench for ulpb_tx_queue with an emulated node on the
// ACK_TX side and a queue-level reference model of the message stream.
module tb_ulpb_tx_queue;

  localparam int DEPTH = 4;
  localparam int TO    = 8;
`ifdef ULPB_TXQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RESET;
  logic [7:0]  WR_ADDR;
  logic [31:0] WR_DATA;
  logic        WR_EN;
  logic        FULL, EMPTY, DROP, REQ_TX, ACK_TX, SENT, TIMEOUT_ERR;
  logic [2:0]  COUNT;
  logic [7:0]  ADDR_OUT;
  logic [31:0] DATA_OUT;

  ulpb_tx_queue #(
    .ADDR_WIDTH (8),
    .DATA_WIDTH (32),
    .DEPTH      (DEPTH),
    .TIMEOUT    (TO)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .WR_ADDR     (WR_ADDR),
    .WR_DATA     (WR_DATA),
    .WR_EN       (WR_EN),
    .FULL        (FULL),
    .EMPTY       (EMPTY),
    .COUNT       (COUNT),
    .DROP        (DROP),
    .ADDR_OUT    (ADDR_OUT),
    .DATA_OUT    (DATA_OUT),
    .REQ_TX      (REQ_TX),
    .ACK_TX      (ACK_TX),
    .SENT        (SENT),
    .TIMEOUT_ERR (TIMEOUT_ERR)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_err    = 0;

  logic [39:0] stim_q[$];
  logic [39:0] exp_msgs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Emulated node: raises ACK_TX ack_delay cycles into REQ, holds it
  // ack_hold cycles after REQ_TX falls; node_mute never acknowledges.
  int ack_delay = 3;
  int ack_hold  = 0;
  bit node_mute = 1'b0;
  int node_hi   = 0;
  int node_hc   = 0;

  always @(negedge CLK) begin
    #2;
    if (!ACK_TX) begin
      if (REQ_TX && !node_mute) begin
        node_hi++;
        if (node_hi >= ack_delay) begin
          ACK_TX  = 1'b1;
          node_hc = 0;
        end
      end else begin
        node_hi = 0;
      end
    end else if (!REQ_TX) begin
      if (node_hc >= ack_hold) begin
        ACK_TX  = 1'b0;
        node_hi = 0;
      end else begin
        node_hc++;
      end
    end
  end

  // Monitor: advances the reference model by one clock edge using the inputs
  // that edge sampled, then compares every output.
  bit m_req       = 1'b0;
  bit m_prev_ack  = 1'b0;
  bit m_prev_terr = 1'b0;
  int m_hi        = 0;

  always @(negedge CLK) begin
    logic [39:0] msg, popped;
    bit wr, ack, acc, pop, e_req, e_sent, e_terr, e_drop;
    wr = WR_EN; ack = ACK_TX;
    msg = '0; popped = '0;
    acc = 1'b0; pop = 1'b0; e_sent = 1'b0; e_terr = 1'b0; e_drop = 1'b0; e_req = 1'b0;
    if (wr && stim_q.size() > 0) msg = stim_q.pop_front();
    if (RESET) begin
      exp_msgs.delete();
      m_hi = 0;
      chk("rst_addr", ADDR_OUT, 0);
      chk("rst_data", DATA_OUT, 0);
    end else begin
      e_drop = wr && (exp_msgs.size() == DEPTH);
      acc    = wr && (exp_msgs.size() < DEPTH);
      if (m_req) begin
        if (ack) begin
          e_sent = 1'b1; pop = 1'b1;
        end else if (TO_EN && m_hi == TO) begin
          e_terr = 1'b1; pop = 1'b1;
        end else begin
          e_req = 1'b1;
        end
      end else begin
        e_req = !ack && !m_prev_ack && !m_prev_terr && (exp_msgs.size() > 0);
      end
      if (pop) popped = exp_msgs.pop_front();
      if (acc) exp_msgs.push_back(msg);
      m_hi = e_req ? m_hi + 1 : 0;
      if (e_req) begin
        chk("req_addr", ADDR_OUT, exp_msgs[0][39:32]);
        chk("req_data", DATA_OUT, exp_msgs[0][31:0]);
      end
      if (pop) begin
        chk("done_addr", ADDR_OUT, popped[39:32]);
        chk("done_data", DATA_OUT, popped[31:0]);
      end
    end
    chk("req_tx", REQ_TX, e_req);
    chk("sent", SENT, e_sent);
    chk("timeout_err", TIMEOUT_ERR, e_terr);
    chk("drop", DROP, e_drop);
    chk("count", COUNT, exp_msgs.size());
    chk("empty", EMPTY, exp_msgs.size() == 0);
    chk("full", FULL, exp_msgs.size() == DEPTH);
    m_req       = e_req;
    m_prev_ack  = ack;
    m_prev_terr = e_terr;
  end

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic put(input logic [7:0] a, input logic [31:0] d);
    WR_EN   = 1'b1;
    WR_ADDR = a;
    WR_DATA = d;
    stim_q.push_back({a, d});
    tick();
  endtask

  task automatic idle(input int n);
    WR_EN = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drain(input int max_cycles);
    WR_EN = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      if (EMPTY && !REQ_TX && !ACK_TX) break;
      tick();
    end
    chk("drain_idle", {EMPTY, REQ_TX}, 2'b10);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1; WR_EN = 1'b0; WR_ADDR = '0; WR_DATA = '0; ACK_TX = 1'b0;
    tick(); tick();
    RESET = 1'b0;

    // single message, node acknowledges 3 cycles into REQ
    ack_delay = 3;
    put(8'hab, 32'habcdef12);
    idle(1);
    drain(40);

    // fill the queue back to back; the fifth write is dropped
    ack_delay = 4;
    for (int i = 0; i < 5; i++) put(8'h10 + 8'(i), 32'h1000_0000 + 32'(i));
    drain(80);

    // write lands on the same edge as an acknowledge pop with COUNT=2
    ack_delay = 3;
    put(8'h21, 32'h2121_2121);
    put(8'h22, 32'h2222_2222);
    idle(2);
    put(8'h23, 32'h2323_2323);
    drain(60);

    // node keeps ACK_TX high 5 cycles after REQ_TX falls
    ack_delay = 2; ack_hold = 5;
    put(8'h31, 32'h3131_3131);
    put(8'h32, 32'h3232_3232);
    drain(60);
    ack_hold = 0;

    // reset in the middle of a request with three messages queued
    node_mute = 1'b1;
    put(8'h41, 32'h4141_4141);
    put(8'h42, 32'h4242_4242);
    put(8'h43, 32'h4343_4343);
    idle(2);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    node_mute = 1'b0;
    idle(3);

`ifdef ULPB_TXQ_TIMEOUT_EN
    // silent node: both messages are abandoned in turn
    node_mute = 1'b1;
    put(8'h51, 32'h5151_5151);
    put(8'h52, 32'h5252_5252);
    idle(30);
    node_mute = 1'b0;
    drain(40);
`endif

    // random traffic with occasional resets and varying node timing
    for (int c = 0; c < 600; c++) begin
      if (c % 50 == 0) begin
        ack_delay = $urandom_range(1, 5);
        ack_hold  = $urandom_range(0, 4);
      end
      RESET = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 2) != 0) begin
        put(8'($urandom), 32'($urandom));
      end else begin
        idle(1);
      end
    end
    RESET = 1'b0;
    drain(300);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
